// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: the fetch unit is the master, memory the slave.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / instruction register owner for the multi-cycle CPU.
// Fetches over a req/ack bus, decodes jump/branch opcodes for the
// combinational next-PC block and advances the PC from its npc result.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_fetch_unit_if.master        imem,
    input  logic                   br_cond_i,
    input  logic                   stall_i,
    output logic [31:0]            pc_o,
    output logic [25:0]            addr_o,
    output logic [15:0]            offset_o,
    output logic [1:0]             npcctrol_o,
    input  logic [31:0]            npc_i,
    output logic [31:0]            instr_o,
    output logic                   instr_valid_o,
    output logic [31:0]            retired_o,
    output logic                   err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_JUMP   = 2'b01;
    localparam logic [1:0] NPC_BRANCH = 2'b10;

    logic [1:0]  state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] instr_q,   instr_d;
    logic [31:0] retired_q, retired_d;
    logic        err_q,     err_d;
    logic [1:0]  npcctrol;

    // Next-PC select: only meaningful while the instruction is being issued.
    always_comb begin
        npcctrol = NPC_SEQ;
        if (state_q == S_ISSUE) begin
            case (instr_q[31:26])
                OP_J, OP_JAL: npcctrol = NPC_JUMP;
                OP_BEQ:       npcctrol = br_cond_i ? NPC_BRANCH : NPC_SEQ;
                default:      npcctrol = NPC_SEQ;
            endcase
        end
    end

    // FSM sequencing and register next-state; a misaligned npc parks the unit in HALT.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall_i) begin
                    if (npc_i[1:0] == 2'b00) begin
                        pc_d      = npc_i;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;

    assign pc_o          = pc_q;
    assign addr_o        = instr_q[25:0];
    assign offset_o      = instr_q[15:0];
    assign npcctrol_o    = npcctrol;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == S_ISSUE);
    assign retired_o     = retired_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: randomized instruction stream against
// a transaction-level model of the PC, plus directed corner cases.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_cond = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc;
    logic [25:0] addr;
    logic [15:0] offset;
    logic [1:0]  npcctrol;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] retired;
    logic        err;

    logic        force_npc = 1'b0;
    logic [31:0] npc_force = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ret;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (bus.master),
        .br_cond_i     (br_cond),
        .stall_i       (stall),
        .pc_o          (pc),
        .addr_o        (addr),
        .offset_o      (offset),
        .npcctrol_o    (npcctrol),
        .npc_i         (npc),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .retired_o     (retired),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational next-PC block, with an override for error injection.
    always_comb begin
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        case (npcctrol)
            2'b01:   npc = {pc4[31:28], addr, 2'b00};
            2'b10:   npc = pc4 + {{14{offset[15]}}, offset, 2'b00};
            default: npc = pc4;
        endcase
        if (force_npc) npc = npc_force;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural expectations, straight from the opcode rules.
    function automatic logic [1:0] exp_ctrl(input logic [31:0] w, input logic brc);
        if (w[31:26] == 6'd2 || w[31:26] == 6'd3) return 2'b01;
        if (w[31:26] == 6'd4 && brc) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_npc(input logic [31:0] p, input logic [31:0] w, input logic brc);
        logic [31:0] seq;
        seq = p + 4;
        case (exp_ctrl(w, brc))
            2'b01:   return {seq[31:28], w[25:0], 2'b00};
            2'b10:   return seq + (32'(signed'(w[15:0])) * 4);
            default: return seq;
        endcase
    endfunction

    // Reset (with a stray ack during reset) and release to the first FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        step();
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_ctrl", 32'(npcctrol), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ret", retired, 0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = $urandom | 32'h1;
        step();
        bus.imem_ack = 1'b0;
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, RESET_PC);
        rst_n = 1'b1;
        #1;
        chk("idle_req", 32'(bus.imem_req), 0);
        step();
        chk("first_req", 32'(bus.imem_req), 1);
        chk("first_addr", bus.imem_addr, RESET_PC);
        m_pc  = RESET_PC;
        m_ret = 0;
    endtask

    // One instruction from FETCH through ISSUE exit; returns with the unit in FETCH or HALT.
    task automatic do_instr(input logic [31:0] w, input logic brc, input int waits,
                            input int stalls, input logic mis);
        logic b;
        logic [31:0] target;
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack = 1'b0;
            bus.imem_rdata = $urandom;
            #1;
            chk("wait_req", 32'(bus.imem_req), 1);
            chk("wait_addr", bus.imem_addr, m_pc);
            chk("wait_valid", 32'(instr_valid), 0);
            step();
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = w;
        #1;
        chk("fetch_req", 32'(bus.imem_req), 1);
        chk("fetch_addr", bus.imem_addr, m_pc);
        chk("fetch_ctrl", 32'(npcctrol), 0);
        step();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = $urandom;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            b = 1'($urandom);
            br_cond = b;
            #1;
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_ctrl", 32'(npcctrol), 32'(exp_ctrl(w, b)));
            chk("stall_pc", pc, m_pc);
            chk("stall_ret", retired, m_ret);
            chk("stall_req", 32'(bus.imem_req), 0);
            step();
        end
        stall = 1'b0;
        br_cond = brc;
        force_npc = mis;
        npc_force = m_pc + 32'd6;
        #1;
        chk("issue_valid", 32'(instr_valid), 1);
        chk("issue_instr", instr, w);
        chk("issue_addr", 32'(addr), 32'(w[25:0]));
        chk("issue_off", 32'(offset), 32'(w[15:0]));
        chk("issue_ctrl", 32'(npcctrol), 32'(exp_ctrl(w, brc)));
        target = exp_npc(m_pc, w, brc);
        step();
        force_npc = 1'b0;
        bus.imem_ack = 1'b0;
        if (mis) begin
            chk("halt_err", 32'(err), 1);
            chk("halt_pc", pc, m_pc);
            chk("halt_req", 32'(bus.imem_req), 0);
        end else begin
            m_pc = target;
            m_ret = m_ret + 1;
            chk("next_req", 32'(bus.imem_req), 1);
            chk("next_addr", bus.imem_addr, m_pc);
            chk("next_ret", retired, m_ret);
            chk("next_err", 32'(err), 0);
        end
    endtask

    initial begin
        logic [31:0] w;
        int kind;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0;
        step();
        do_reset();

        // Sequential nops, zero-wait.
        for (int i = 0; i < 3; i++) do_instr(32'h0, 1'b0, 0, 0, 1'b0);
        chk("seq_pc", pc, 32'h300C);
        chk("seq_ret", retired, 3);

        // Jump and both branch directions from RESET_PC.
        do_reset();
        do_instr(32'h08000C10, 1'b0, 0, 0, 1'b0);
        chk("jump_addr", bus.imem_addr, 32'h3040);
        do_reset();
        do_instr(32'h10000003, 1'b1, 0, 0, 1'b0);
        chk("beq_t_addr", bus.imem_addr, 32'h3010);
        do_reset();
        do_instr(32'h10000003, 1'b0, 0, 0, 1'b0);
        chk("beq_nt_addr", bus.imem_addr, 32'h3004);

        // Wait states and stall.
        do_instr(32'h0, 1'b0, 3, 2, 1'b0);
        chk("ws_addr", bus.imem_addr, 32'h3008);

        // Misaligned npc -> HALT; ack ignored there; reset recovers.
        do_reset();
        do_instr(32'h0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.imem_ack = 1'($urandom);
            stall = 1'($urandom);
            br_cond = 1'($urandom);
            #1;
            chk("halt_req_hold", 32'(bus.imem_req), 0);
            chk("halt_valid", 32'(instr_valid), 0);
            chk("halt_ctrl", 32'(npcctrol), 0);
            chk("halt_pc_hold", pc, 32'h3000);
            chk("halt_err_hold", 32'(err), 1);
            step();
        end
        stall = 1'b0;

        // Reset in the middle of a fetch with ack withheld.
        do_reset();
        chk("post_halt_err", 32'(err), 0);
        bus.imem_ack = 1'b0;
        step();
        chk("midfetch_req", 32'(bus.imem_req), 1);
        do_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 4);
            w = $urandom;
            case (kind)
                0: if (w[31:26] inside {6'd2, 6'd3, 6'd4}) w[31:26] = 6'd0;
                1: w[31:26] = 6'd2;
                2: w[31:26] = 6'd3;
                default: w[31:26] = 6'd4;
            endcase
            do_instr(w, (kind == 3) ? 1'b1 : ((kind == 4) ? 1'b0 : 1'($urandom)),
                     ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                     ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Sequential owner of the program counter and instruction register for the multi-cycle CPU. Fetches from instruction memory over a req/ack handshake and decodes jump/branch opcodes into the `pc`/`addr`/`offset`/`npcctrol` inputs of the combinational next-PC block. It consumes that block's `npc` result to advance the PC. It is the driving end of the next-PC interface.

## Interface
- `RESET_PC`, default 32'h00003000, PC value loaded on reset; must be word aligned.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `br_cond`  in  1  beq compare result (rs==rt) for the instruction in `instr`; sampled only in ISSUE.
- `stall`  in  1  pipeline hold; blocks PC update.
- `pc`  out  32  current PC, to next-PC block.
- `addr`  out  26  `instr[25:0]`, to next-PC block.
- `offset`  out  16  `instr[15:0]`, to next-PC block.
- `npcctrol`  out  2  00 = pc+4, 01 = jump, 10 = branch; 11 never driven.
- `npc`  in  32  next PC returned by the next-PC block, same cycle.
- `instr`  out  32  instruction register.
- `instr_valid`  out  1  `instr` is valid for downstream decode.
- `retired`  out  32  count of completed PC updates.
- `err`  out  1  sticky misaligned-npc error.

## Operation
- The FSM has four states:
  - IDLE: `imem_req`=0. Always moves to FETCH on the next cycle.
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`.
    - On `imem_ack`=1: `instr`<=`imem_rdata`, then go to ISSUE.
    - Otherwise stay in FETCH with request and address held stable.
  - ISSUE: `instr_valid`=1 and `npcctrol` is decoded from `instr[31:26]`:
    - 000010 (j) or 000011 (jal) -> 01.
    - 000100 (beq) with `br_cond`=1 -> 10.
    - Any other opcode, or beq with `br_cond`=0 -> 00.
  - ISSUE exit:
    - If `stall`=1: hold every register and stay in ISSUE; `npcctrol` keeps tracking `br_cond`.
    - If `stall`=0 and `npc[1:0]`==00: `pc`<=`npc`, `retired`<=`retired`+1 (wraps modulo 2^32), go to FETCH.
    - If `stall`=0 and `npc[1:0]`!=00: `pc` is unchanged, `err`<=1, `retired` is unchanged, go to HALT.
  - HALT: all strobes are 0 and `npcctrol`=00. The block leaves HALT only through reset.
- Outside ISSUE, `npcctrol`=00 and `instr_valid`=0.
- `addr` and `offset` always reflect `instr`, in every state.
- `imem_ack` is ignored outside FETCH.
- `imem_rdata` is sampled only on the FETCH cycle in which `imem_ack`=1.

## Timing
- Reset: when `rst_n`=0 is sampled on a rising edge, the following values load, regardless of state or any outstanding request:
  - state = IDLE, `pc` = `RESET_PC`, `instr` = 0, `retired` = 0, `err` = 0.
  - Outputs therefore become `imem_req`=0, `instr_valid`=0, `npcctrol`=00.
- A late `imem_ack` for an abandoned request is not captured, because the state is IDLE when it arrives.
- First `imem_req` is asserted on the second cycle after `rst_n` is first sampled high (IDLE lasts one cycle).
- With a zero-wait memory (`imem_ack` in the same cycle as `imem_req`), one instruction takes 2 cycles: FETCH then ISSUE. Each wait state adds 1 cycle, and each stall cycle adds 1 cycle.
- `npc` is combinational from `pc`/`addr`/`offset`/`npcctrol` and is captured on the ISSUE-exit edge.
- The new `pc` is visible on `imem_addr` in the very next FETCH cycle.
- `imem_addr` must not change while `imem_req`=1 and `imem_ack`=0.

## Test plan
- Sequential fetch: zero-wait memory returning 32'h00000000 (nop), bench models npc = pc+4 -> `imem_addr` sequence 0x3000, 0x3004, 0x3008 on every other cycle; `retired`=3 after 6 cycles in FETCH/ISSUE.
- Jump: `instr`=32'h08000C10 (j) at pc 0x3000 -> `npcctrol`=01 and `addr`=26'h0000C10 in ISSUE; with bench npc=0x00003040, the next `imem_addr`=0x3040.
- Branch: `instr`=32'h10000003 (beq) at pc 0x3000.
  - `br_cond`=1 -> `npcctrol`=10 and `offset`=16'h0003; bench npc=0x3010 -> next fetch at 0x3010.
  - Repeat with `br_cond`=0 -> `npcctrol`=00, next fetch at 0x3004.
- Wait states and stall: hold `imem_ack` low 3 cycles -> `imem_req` and `imem_addr` stay stable for 4 cycles. Then hold `stall` high 2 cycles in ISSUE -> `pc` and `retired` unchanged until `stall` falls.
- Misaligned npc: bench forces npc=0x3006 at ISSUE exit -> `err`=1, state HALT, `imem_req`=0 permanently, `pc` stays 0x3000. A following reset clears `err` and fetch restarts at 0x3000.
- Reset mid-fetch: assert `rst_n`=0 while in FETCH with `imem_ack`=0, then pulse `imem_ack` during reset -> `instr` stays 0, `pc`=0x3000, first new `imem_req` on the second cycle after release.
